irq_ctrl: RTL and testbench

- Interrupt controller between the memory-mapped devices (Timer IRQ outputs, external sources) and CP0.
- Latches up to 6 device interrupt lines into pending bits and applies a per-source mask and edge/level mode.
- Drives CP0's HWInt bus and a single prioritised request/acknowledge/end-of-interrupt handshake.
- Configured through the Bridge using the same ADDR_I/WE_I/DAT_I/DAT_O register protocol as the Timer.

---
 rtl/irq_ctrl.sv | 95 +++++++++
 tb/tb_irq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: mask/edge-level interrupt latching with one prioritised req/ack/EOI handshake to CP0.
// Define IRQ_CTRL_SYNC_EN to pass irq_i through a 2-flop synchronizer (3-cycle irq_i to HWInt latency).
module irq_ctrl #(
    parameter int          N_SRC      = 6,
    parameter logic [31:0] DEBUG_DATA = 32'h20171225
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:2]       ADDR_I,
    input  logic             WE_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] irq_i,
    output logic [N_SRC-1:0] HWInt,
    output logic             int_req,
    output logic [2:0]       int_id,
    input  logic             int_ack
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10} state_e;
    state_e state_q, state_d;
    logic [N_SRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, prev_q, hw_q, hw_d;
    logic [N_SRC-1:0] irq_s, clr, sel;
    logic [2:0] id_q, id_d, prio;
    logic req_q, req_d, wr_mask, wr_mode, wr_pend, wr_eoi;
`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif
    assign wr_mask = WE_I && ADDR_I == 2'b00;
    assign wr_mode = WE_I && ADDR_I == 2'b01;
    assign wr_pend = WE_I && ADDR_I == 2'b10;
    assign wr_eoi  = WE_I && ADDR_I == 2'b11;
    assign sel     = N_SRC'(1) << id_q;
    always_comb begin
        prio = '0;
        for (int i = N_SRC - 1; i >= 0; i--) if (hw_q[i]) prio = 3'(i);
        clr    = (wr_pend ? DAT_I[N_SRC-1:0] : '0) | ((state_q == REQ && int_ack) ? sel & mode_q : '0);
        mask_d = wr_mask ? DAT_I[N_SRC-1:0] : mask_q;
        mode_d = wr_mode ? DAT_I[N_SRC-1:0] : mode_q;
        // edge sources: a new edge outranks any same-cycle clear; level sources simply follow the line
        pend_d = (mode_q & ((irq_s & ~prev_q) | (pend_q & ~clr))) | (~mode_q & irq_s);
        hw_d   = pend_d & mask_d;
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE:    if (|hw_q) begin
                state_d = REQ;
                id_d    = prio;
            end
            REQ:     state_d = int_ack ? SERVICE : (|(hw_q & sel)) ? REQ : IDLE;
            SERVICE: state_d = wr_eoi ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
        req_d = state_d == REQ;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            hw_q    <= '0;
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            prev_q  <= irq_s;
            hw_q    <= hw_d;
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
        end
    end
    assign DAT_O = ADDR_I == 2'b00 ? 32'(mask_q) :
                   ADDR_I == 2'b01 ? 32'(mode_q) :
                   ADDR_I == 2'b10 ? 32'(pend_q) :
                   ADDR_I == 2'b11 ? {24'b0, state_q, id_q, 2'b0, req_q} : DEBUG_DATA;
    assign HWInt   = hw_q;
    assign int_req = req_q;
    assign int_id  = id_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic checked against a per-source behavioural model.
module tb_irq_ctrl;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT  = 3;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit SYNC = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1, we = 1'b0, ack = 1'b0;
    logic [3:2]  addr = 2'b00;
    logic [31:0] dat = '0, dat_o;
    logic [5:0]  irq = '0, hwint;
    logic        int_req;
    logic [2:0]  int_id;
    int checks = 0, failures = 0;
    bit m_mask[6], m_mode[6], m_pend[6], m_prev[6], m_hw[6], m_s1[6], m_s2[6];
    int m_state, m_id;
    bit m_req;

    irq_ctrl dut (
        .clk(clk), .reset(reset), .ADDR_I(addr), .WE_I(we), .DAT_I(dat), .DAT_O(dat_o),
        .irq_i(irq), .HWInt(hwint), .int_req(int_req), .int_id(int_id), .int_ack(ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input bit a[6]);
        logic [31:0] r = '0;
        for (int i = 0; i < 6; i++) r[i] = a[i];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return pack(m_mask);
            2'd1:    return pack(m_mode);
            2'd2:    return pack(m_pend);
            default: return 32'(m_state * 64 + m_id * 8 + int'(m_req));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_mask[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
            m_hw[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_state = 0; m_id = 0; m_req = 0;
    endtask

    task automatic model_step();
        bit x[6], nm[6], nd[6], np[6];
        int lowest = -1;
        for (int i = 0; i < 6; i++) begin
            x[i] = SYNC ? m_s2[i] : irq[i];
            if (SYNC) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = irq[i];
            end
        end
        for (int i = 0; i < 6; i++) begin
            bit rise = x[i] && !m_prev[i];
            bit w1c  = we && addr == 2'd2 && dat[i];
            bit ackc = m_state == 1 && ack && m_id == i;
            if (m_mode[i]) np[i] = rise ? 1'b1 : (w1c || ackc) ? 1'b0 : m_pend[i];
            else np[i] = x[i];
            nm[i] = (we && addr == 2'd0) ? dat[i] : m_mask[i];
            nd[i] = (we && addr == 2'd1) ? dat[i] : m_mode[i];
            if (m_hw[i] && lowest < 0) lowest = i;
        end
        case (m_state)
            0: if (lowest >= 0) begin m_state = 1; m_id = lowest; end
            1: if (ack) m_state = 2; else if (!m_hw[m_id]) m_state = 0;
            default: if (we && addr == 2'd3) m_state = 0;
        endcase
        m_req = m_state == 1;
        for (int i = 0; i < 6; i++) begin
            m_pend[i] = np[i]; m_mask[i] = nm[i]; m_mode[i] = nd[i];
            m_hw[i] = np[i] && nm[i]; m_prev[i] = x[i];
        end
    endtask

    task automatic cyc();
        #1;
        chk("dat_o", dat_o, model_read(addr));
        model_step();
        @(posedge clk);
        #1;
        chk("hwint", 32'(hwint), pack(m_hw));
        chk("int_req", 32'(int_req), 32'(m_req));
        if (m_req) chk("int_id", 32'(int_id), 32'(m_id));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; dat = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        we = 1'b0; addr = a;
        #1;
        chk(tag, dat_o, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; ack = 1'b0; irq = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_hwint", 32'(hwint), 32'h0);
        chk("rst_req", 32'(int_req), 32'h0);
        for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();
        // edge source 0 through ack and EOI
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h01);
        irq = 6'h01; cyc(); irq = '0;
        repeat (LAT - 1) cyc();
        chk("t1_hwint", 32'(hwint), 32'h01);
        cyc();
        chk("t1_req", 32'(int_req), 32'h1);
        chk("t1_id", 32'(int_id), 32'h0);
        ack = 1'b1; cyc(); ack = 1'b0;
        rd("t1_pend", 2'd2, 32'h0);
        rd("t1_status", 2'd3, 32'h80);
        wr(2'd3, 32'h0);
        cyc();
        chk("t1_req_eoi", 32'(int_req), 32'h0);
        rd("t1_idle", 2'd3, 32'h0);
        // two simultaneous sources serviced in priority order
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h3F);
        irq = 6'h0A; cyc(); irq = '0;
        repeat (LAT) cyc();
        chk("t2_id1", 32'(int_id), 32'h1);
        ack = 1'b1; cyc(); ack = 1'b0;
        wr(2'd3, 32'h0);
        cyc();
        chk("t2_req3", 32'(int_req), 32'h1);
        chk("t2_id3", 32'(int_id), 32'h3);
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("t2_hw0", 32'(hwint), 32'h0);
        wr(2'd3, 32'h0);
        cyc();
        chk("t2_idle", 32'(int_req), 32'h0);
        // held level source re-requests after EOI
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h04);
        irq = 6'h04;
        repeat (LAT + 1) cyc();
        chk("t3_id2", 32'(int_id), 32'h2);
        ack = 1'b1; cyc(); ack = 1'b0;
        wr(2'd3, 32'h0);
        cyc();
        chk("t3_rereq", 32'(int_req), 32'h1);
        chk("t3_reid", 32'(int_id), 32'h2);
        ack = 1'b1; cyc(); ack = 1'b0;
        irq = '0;
        repeat (LAT) cyc();
        wr(2'd3, 32'h0);
        cyc();
        chk("t3_req0", 32'(int_req), 32'h0);
        chk("t3_hw0", 32'(hwint), 32'h0);
        // masking the requested source withdraws the request but keeps it pending
        wr(2'd1, 32'h10);
        wr(2'd0, 32'h10);
        irq = 6'h10; cyc(); irq = '0;
        repeat (LAT) cyc();
        chk("t4_id4", 32'(int_id), 32'h4);
        wr(2'd0, 32'h0);
        chk("t4_hw0", 32'(hwint), 32'h0);
        cyc();
        chk("t4_req0", 32'(int_req), 32'h0);
        rd("t4_pend", 2'd2, 32'h10);
        wr(2'd2, 32'h10);
        rd("t4_w1c", 2'd2, 32'h0);
        // edge arriving together with W1C of the same bit survives
        wr(2'd1, 32'h20);
        wr(2'd0, 32'h20);
        irq = 6'h20;
        repeat (LAT - 1) cyc();
        wr(2'd2, 32'h20);
        irq = '0;
        rd("t5_pend", 2'd2, 32'h20);
        cyc();
        chk("t5_id5", 32'(int_id), 32'h5);
        rd("t5_status", 2'd3, 32'h69);
        ack = 1'b1; cyc(); ack = 1'b0;
        // reset from SERVICE with masked pending bits
        wr(2'd1, 32'h2A);
        irq = 6'h0A; cyc(); irq = '0;
        repeat (LAT) cyc();
        rd("t6_pend", 2'd2, 32'h0A);
        rd("t6_status", 2'd3, 32'hA8);
        do_reset();
        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 6; i++) if ($urandom_range(0, 5) == 0) irq[i] = ~irq[i];
            we = $urandom_range(0, 5) == 0;
            addr = 2'($urandom_range(0, 3));
            dat = $urandom;
            if (m_state == 2 && $urandom_range(0, 7) == 0) begin
                we = 1'b1;
                addr = 2'd3;
            end
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            cyc();
        end
        we = 1'b0; ack = 1'b0; irq = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
